nmcu_mem_responder: RTL

Memory-side responder for the NMCU chiplet's memory master port. It models the HBM/DDR/SRAM endpoint with a word-addressed on-chip array, a programmable read latency, read bursts, byte-strobed single-beat writes and error responses. It stands in for external memory in block and chiplet-level simulation. It is also the synthesizable scratch SRAM for small configurations.

---
 rtl/nmcu_mem_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nmcu_mem_responder.sv
// Memory-side responder for the NMCU memory master port: word array with
// programmable read latency, read bursts, byte-strobed writes and error beats.
module nmcu_mem_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 4,
  parameter int BURST_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [BURST_WIDTH-1:0]  req_len,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_last,
  output logic                    resp_write,
  output logic                    resp_error,
  output logic                    busy,
  output logic [1:0]              fsm_state
);

  // Handshakes: a request is taken in any cycle with req_valid && req_ready;
  // a response beat is consumed in any cycle with resp_valid && resp_ready.
  // Once raised, resp_valid and the beat payload hold until consumed.

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH_WORDS);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LAT   = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH_WORDS);
  localparam logic [LAT_W-1:0]    LAT_INIT = LAT_W'(READ_LATENCY - 1);

  logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

  logic [1:0]             state;
  logic [LAT_W-1:0]       lat_cnt;
  logic [BURST_WIDTH-1:0] remain;
  logic [IW-1:0]          ptr;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   write_q;
  logic                   error_q;

  logic [ADDR_WIDTH-1:0]  idx_full;
  logic [IW-1:0]          idx;
  logic [ADDR_WIDTH:0]    end_x;
  logic                   misaligned;
  logic                   req_error;
  logic                   accept;

  assign idx_full   = req_addr >> OFF;
  assign idx        = idx_full[IW-1:0];
  assign end_x      = {1'b0, idx_full} + {{(ADDR_WIDTH + 1 - BURST_WIDTH){1'b0}}, req_len};
  assign misaligned = (req_addr[OFF-1:0] != '0);
  assign req_error  = misaligned ||
                      (req_write ? ({1'b0, idx_full} >= DEPTH_X) : (end_x >= DEPTH_X));
  assign accept     = req_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      remain  <= '0;
      ptr     <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            error_q <= req_error;
            ptr     <= idx;
            remain  <= req_len;
            if (req_error || req_write) begin
              state <= RESP;
            end else if (READ_LATENCY == 1) begin
              state   <= BURST;
              rdata_q <= mem[idx];
            end else begin
              state   <= LAT;
              lat_cnt <= LAT_INIT;
            end
          end
        end
        LAT: begin
          // Leaving on the count reaching zero puts the first beat at T+READ_LATENCY.
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            state   <= BURST;
            rdata_q <= mem[ptr];
          end
        end
        BURST: begin
          if (resp_ready) begin
            if (remain == '0) begin
              state <= IDLE;
            end else begin
              remain  <= remain - BURST_WIDTH'(1);
              ptr     <= ptr + IW'(1);
              rdata_q <= mem[ptr + IW'(1)];
            end
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a write landing in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_write && !req_error) begin
      for (int i = 0; i < BYTES; i++) begin
        if (req_wstrb[i]) mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == BURST) || (state == RESP);
  assign resp_rdata = (state == BURST) ? rdata_q : '0;
  assign resp_last  = (state == RESP) || ((state == BURST) && (remain == '0));
  assign resp_write = (state == RESP) && write_q;
  assign resp_error = (state == RESP) && error_q;
  assign fsm_state  = state;

endmodule
